round_scheduler: RTL
====================

// Module: round_scheduler
// PURPOSE
//  Top-level sequencer for the multi-round permutation datapath.
//  Launches each step unit (own start/ready controller) in fixed order, NUM_UNITS steps per round, for NUM_ROUNDS rounds.
//  Drives the round index used by constant logic, the state-register load and the input/feedback mux select.
//  Sits between the system start/done handshake and the per-step controllers.
// PARAMETERS
//  NUM_UNITS   5   step units per round, launched in index order 0..NUM_UNITS-1
//  NUM_ROUNDS 24   rounds per permutation
//  UNIT_W      3   width of unit index, >= clog2(NUM_UNITS)
//  ROUND_W     5   width of round index, >= clog2(NUM_ROUNDS)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-high
//  start      in   1          begin permutation; sampled only in Idle
//  unitReady  in   NUM_UNITS  per-unit ready (high when that unit is idle)
//  ready      out  1          scheduler idle, may accept start
//  unitStart  out  NUM_UNITS  one-hot, single-cycle start to current unit
//  unitIdx    out  UNIT_W     index of unit currently launched/awaited
//  round      out  ROUND_W    current round index, 0..NUM_ROUNDS-1
//  selInput   out  1          1: datapath takes external input; 0: state feedback
//  ldState    out  1          load state register with last unit's output
//  outReady   out  1          single-cycle pulse: permutation result valid
// BEHAVIOUR
//  - Moore FSM. All outputs are decoded from present state and counters only.
//  - Reset values: state=Idle, unitIdx=0, round=0; ready=1; all other outputs 0.
//  - States and transitions:
//    Idle: ready=1. start -> Init, else stay.
//    Init: clear unitIdx and round -> Launch.
//    Launch: unitStart[unitIdx]=1 for exactly one cycle -> Busy.
//    Busy: wait for unitReady[unitIdx]==0 (acknowledge); 0 -> Wait, else stay.
//    Wait: wait for unitReady[unitIdx]==1 (completion); 1 -> Advance, else stay.
//    Advance, unitIdx<NUM_UNITS-1: unitIdx++ -> Launch.
//    Advance, unitIdx==NUM_UNITS-1: ldState=1 and unitIdx<=0.
//      If round==NUM_ROUNDS-1 -> Done; else round++ -> Launch.
//    Done: outReady=1 -> Idle.
//  - selInput=1 whenever round==0 && unitIdx==0 and state is Launch/Busy/Wait/Advance; 0 otherwise.
//  - unitReady bits of non-selected units are ignored.
//  - Unit latency L = cycles unitReady stays low after Launch (L>=1).
//    Each unit slot costs L+3 cycles.
//    Full run = 2 + NUM_UNITS*NUM_ROUNDS*(L+3) cycles from start-sampling edge to outReady.
//  - start outside Idle is ignored; a held start re-triggers only after returning to Idle.
//  - Counters never wrap: round and unitIdx reach max only at Advance, then clear or exit.
//  - Async rst mid-operation: immediate return to reset values.
//    Any unitStart pulse in flight is dropped. No partial ldState or outReady.
//  - A unit that never drops or never raises ready hangs the FSM in Busy/Wait. No timeout.
// STRUCTURE
//  - Shared header round_defs.vh: state encodings (3 bits: Idle, Init, Launch, Busy, Wait, Advance, Done).
//    Also default NUM_UNITS/NUM_ROUNDS values.
//  - One sub-module, mod_counter (parameterised width/modulus; clr, en, count, co).
//    Instantiated twice: unit index, and round index chained on unit co.
//  - unitStart decoded one-hot from unitIdx, gated by Launch.
// TESTING
//  - Reset: assert rst mid-Wait -> next cycle ready=1, unitStart=0, round=0, unitIdx=0, outReady=0.
//  - NUM_UNITS=2, NUM_ROUNDS=3, model L=4: start pulse -> unitStart sequence 01,10 x3 rounds.
//    ldState pulses 3 times. outReady exactly 44 cycles after start edge.
//  - Same config: selInput high only during first unit slot. round output steps 0,1,2.
//  - start held high throughout: second run begins 2 cycles after outReady (Idle->Init). No starts issued mid-run.
//  - Non-selected unit toggles unitReady during Wait -> no effect on FSM timing.
//  - Unit with L=1 (ready low one cycle) -> slot takes 4 cycles; unit never raising ready -> FSM stays in Wait, no outReady.

Source files
------------

// File: rtl/round_scheduler_pkg.sv
// Shared types for the permutation round scheduler: FSM state encoding and
// default geometry of the datapath.
package round_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_BUSY    = 3'd3,
    ST_WAIT    = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam int DEF_NUM_UNITS  = 5;
  localparam int DEF_NUM_ROUNDS = 24;

endpackage

// File: rtl/round_scheduler_mod_counter.sv
// Modulo counter with synchronous clear and enable; co flags the enabled
// increment that wraps from MOD-1 back to zero.
module round_scheduler_mod_counter #(
  parameter int W   = 3,
  parameter int MOD = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         co
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  logic at_max;

  assign at_max = (count == MAX);
  assign co     = en && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/round_scheduler.sv
// Sequencer for the multi-round permutation: launches each step unit in
// index order, NUM_UNITS per round, for NUM_ROUNDS rounds.
module round_scheduler
  import round_scheduler_pkg::*;
#(
  parameter int NUM_UNITS  = DEF_NUM_UNITS,
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int UNIT_W     = 3,
  parameter int ROUND_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_UNITS-1:0] unitReady,
  output logic                 ready,
  output logic [NUM_UNITS-1:0] unitStart,
  output logic [UNIT_W-1:0]    unitIdx,
  output logic [ROUND_W-1:0]   round,
  output logic                 selInput,
  output logic                 ldState,
  output logic                 outReady,
  output state_t               dbg_state
);

  // Unit handshake: start is a one-cycle pulse in Launch; the selected unit
  // acknowledges by dropping unitReady and completes by raising it again.

  state_t state, state_nxt;

  logic [NUM_UNITS-1:0] unit_dec;
  logic                 sel_ready;
  logic                 unit_co;
  logic                 round_co;
  logic                 cnt_clr;
  logic                 unit_en;

  assign cnt_clr   = (state == ST_INIT);
  assign unit_en   = (state == ST_ADVANCE);
  assign dbg_state = state;

  round_scheduler_mod_counter #(
    .W   (UNIT_W),
    .MOD (NUM_UNITS)
  ) u_unit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (unit_en),
    .count (unitIdx),
    .co    (unit_co)
  );

  // Round index advances only when the last unit of the round finishes.
  round_scheduler_mod_counter #(
    .W   (ROUND_W),
    .MOD (NUM_ROUNDS)
  ) u_round_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (unit_co),
    .count (round),
    .co    (round_co)
  );

  always_comb begin
    unit_dec = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_dec[i] = (unitIdx == UNIT_W'(i));
    end
  end

  assign sel_ready = |(unitReady & unit_dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_INIT;
      ST_INIT:    state_nxt = ST_LAUNCH;
      ST_LAUNCH:  state_nxt = ST_BUSY;
      ST_BUSY:    if (!sel_ready) state_nxt = ST_WAIT;
      ST_WAIT:    if (sel_ready) state_nxt = ST_ADVANCE;
      ST_ADVANCE: state_nxt = round_co ? ST_DONE : ST_LAUNCH;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == ST_IDLE);
    unitStart = (state == ST_LAUNCH) ? unit_dec : '0;
    ldState   = unit_co;
    outReady  = (state == ST_DONE);
    selInput  = 1'b0;
    if ((round == '0) && (unitIdx == '0)) begin
      selInput = (state == ST_LAUNCH) || (state == ST_BUSY) ||
                 (state == ST_WAIT)   || (state == ST_ADVANCE);
    end
  end

endmodule
